l2_nway_control: RTL and testbench

Parametrised controller for the set-associative L2 cache, replacing the fixed 4-way control. It sits between the L1 arbiter and physical memory and drives the way tag/data/valid/dirty arrays. It adds the following over the fixed-width controller:
- per-set tree pseudo-LRU storage;
- invalid-way-first victim choice;
- dirty write-back;
- a flush mode that writes back every dirty line.

---
 rtl/l2_nway_control_pkg.sv | 14 +
 rtl/l2_nway_control_plru.sv | 33 +++
 rtl/l2_nway_control.sv | 159 +++++++++++++++
 tb/tb_l2_nway_control.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_nway_control_pkg.sv
// l2_nway_control_pkg: shared types and helpers for the N-way L2 cache controller.
package l2_nway_control_pkg;

    typedef enum logic [2:0] {CHECK, WB, FILL, FL_SCAN, FL_WB} lc3b_l2_cstate;

    localparam int lc3b_l2_ways = 4;

    function automatic int lowest_one(input logic [63:0] v);
        lowest_one = 0;
        for (int i = 63; i >= 0; i--)
            if (v[i]) lowest_one = i;
    endfunction

endpackage

// File: rtl/l2_nway_control_plru.sv
// l2_plru_tree: tree pseudo-LRU victim selection and access update for one set.
module l2_plru_tree #(
    parameter int WAYS = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  bits,
    input  logic [WAY_W-1:0] way,
    output logic [WAY_W-1:0] victim,
    output logic [WAYS-2:0]  next_bits
);

    // Nodes are heap-ordered: node i has children 2i+1 and 2i+2, leaves follow the last node.
    logic [WAYS-1:0] ext, nb;
    logic [WAY_W:0]  n, m, p;

    always_comb begin
        ext = {1'b0, bits};
        n = '0;
        for (int l = 0; l < WAY_W; l++)
            n = {n[WAY_W-1:0], 1'b1} + (WAY_W+1)'(ext[n[WAY_W-1:0]]);
        victim = WAY_W'(n - (WAY_W+1)'(WAYS-1));
        nb = ext;
        m = {1'b0, way} + (WAY_W+1)'(WAYS-1);
        p = '0;
        for (int l = 0; l < WAY_W; l++) begin
            p = (m - (WAY_W+1)'(1)) >> 1;
            nb[p[WAY_W-1:0]] = m[0];
            m = p;
        end
        next_bits = nb[WAYS-2:0];
    end

endmodule

// File: rtl/l2_nway_control.sv
// l2_nway_control: set-associative L2 controller with tree PLRU, dirty write-back and flush.
module l2_nway_control
    import l2_nway_control_pkg::*;
#(
    parameter int WAYS = lc3b_l2_ways,
    parameter int SETS = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [IDX_W-1:0] mem_index,
    output logic             mem_resp,
    input  logic             flush_req,
    output logic             flush_done,
    input  logic [WAYS-1:0]  way_hit,
    input  logic [WAYS-1:0]  way_valid,
    input  logic [WAYS-1:0]  way_dirty,
    output logic [IDX_W-1:0] array_index,
    output logic [WAYS-1:0]  load_td,
    output logic [WAYS-1:0]  load_valid,
    output logic [WAYS-1:0]  load_dirty,
    output logic             valid_in,
    output logic             dirty_in,
    output logic             datain_sel,
    output logic             pmem_addr_sel,
    output logic [WAY_W-1:0] sel_way,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp
);

    lc3b_l2_cstate    state, next;
    logic [WAYS-2:0]  plru [SETS];
    logic [WAYS-2:0]  plru_next;
    logic [IDX_W-1:0] cnt;
    logic [WAY_W-1:0] vic, vic_d, hit_way, inv_way, dv_way, tree_vic, miss_vic;
    logic [WAYS-1:0]  hit_oh, vic_oh;
    logic             req, hit, plru_we, vic_we, cnt_clr, cnt_inc;

    assign req      = mem_read | mem_write;
    assign hit      = |way_hit;
    assign hit_way  = WAY_W'(lowest_one(64'(way_hit)));
    assign inv_way  = WAY_W'(lowest_one(64'(~way_valid)));
    assign dv_way   = WAY_W'(lowest_one(64'(way_valid & way_dirty)));
    assign miss_vic = (&way_valid) ? tree_vic : inv_way;
    assign hit_oh   = WAYS'(1) << hit_way;
    assign vic_oh   = WAYS'(1) << vic;

    l2_plru_tree #(.WAYS(WAYS)) u_plru (
        .bits(plru[mem_index]),
        .way(hit_way),
        .victim(tree_vic),
        .next_bits(plru_next)
    );

    always_comb begin
        next = state;
        mem_resp = 1'b0;
        flush_done = 1'b0;
        array_index = mem_index;
        load_td = '0;
        load_valid = '0;
        load_dirty = '0;
        valid_in = 1'b0;
        dirty_in = 1'b0;
        datain_sel = 1'b0;
        pmem_addr_sel = 1'b0;
        sel_way = '0;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        plru_we = 1'b0;
        vic_we = 1'b0;
        vic_d = miss_vic;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            CHECK: begin
                if (req && hit) begin
                    mem_resp = 1'b1;
                    sel_way = hit_way;
                    plru_we = 1'b1;
                    load_td = mem_write ? hit_oh : '0;
                    load_dirty = mem_write ? hit_oh : '0;
                    dirty_in = mem_write;
                end else if (req) begin
                    vic_we = 1'b1;
                    next = (way_valid[miss_vic] && way_dirty[miss_vic]) ? WB : FILL;
                end else if (flush_req) begin
                    cnt_clr = 1'b1;
                    next = FL_SCAN;
                end
            end
            WB: begin
                pmem_write = 1'b1;
                pmem_addr_sel = 1'b1;
                sel_way = vic;
                next = pmem_resp ? FILL : WB;
            end
            FILL: begin
                pmem_read = 1'b1;
                datain_sel = 1'b1;
                sel_way = vic;
                if (pmem_resp) begin
                    load_td = vic_oh;
                    load_valid = vic_oh;
                    load_dirty = vic_oh;
                    valid_in = 1'b1;
                    next = CHECK;
                end
            end
            FL_SCAN: begin
                array_index = cnt;
                if (|(way_valid & way_dirty)) begin
                    vic_we = 1'b1;
                    vic_d = dv_way;
                    next = FL_WB;
                end else if (cnt == IDX_W'(SETS-1)) begin
                    flush_done = 1'b1;
                    next = CHECK;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            FL_WB: begin
                array_index = cnt;
                pmem_write = 1'b1;
                pmem_addr_sel = 1'b1;
                sel_way = vic;
                load_dirty = pmem_resp ? vic_oh : '0;
                next = pmem_resp ? FL_SCAN : FL_WB;
            end
            default: next = CHECK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CHECK;
            cnt <= '0;
            vic <= '0;
            for (int s = 0; s < SETS; s++)
                plru[s] <= '0;
        end else begin
            state <= next;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 1'b1;
            if (vic_we)
                vic <= vic_d;
            if (plru_we)
                plru[mem_index] <= plru_next;
        end
    end

endmodule

// File: tb/tb_l2_nway_control.sv
// tb_l2_nway_control: directed bench with a behavioural way-array model and pmem responder.
module tb_l2_nway_control;

    localparam int WAYS = 4;
    localparam int SETS = 16;
    localparam int LAT  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read, mem_write, mem_resp, flush_req, flush_done;
    logic [3:0] mem_index, array_index;
    logic [3:0] way_hit, way_valid, way_dirty, load_td, load_valid, load_dirty;
    logic       valid_in, dirty_in, datain_sel, pmem_addr_sel, pmem_read, pmem_write;
    logic       pmem_resp = 1'b0;
    logic [1:0] sel_way;

    always #5 clk = ~clk;

    l2_nway_control #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_index(mem_index), .mem_resp(mem_resp),
        .flush_req(flush_req), .flush_done(flush_done),
        .way_hit(way_hit), .way_valid(way_valid), .way_dirty(way_dirty),
        .array_index(array_index), .load_td(load_td), .load_valid(load_valid), .load_dirty(load_dirty),
        .valid_in(valid_in), .dirty_in(dirty_in), .datain_sel(datain_sel),
        .pmem_addr_sel(pmem_addr_sel), .sel_way(sel_way),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
    );

    // Way-array model: tags/valid/dirty per set, written by the DUT's load enables.
    logic [3:0] vld [SETS];
    logic [3:0] drt [SETS];
    logic [7:0] tg  [SETS][WAYS];
    logic [7:0] cur_tag;
    logic       clr, poke, pk_d;
    logic [3:0] pk_s;
    logic [1:0] pk_w;
    logic [7:0] pk_t;
    logic       ovr;
    logic [3:0] t_hit, t_val, t_dty, m_hit;

    always @(posedge clk) begin
        if (clr) begin
            for (int s = 0; s < SETS; s++) begin
                vld[s] <= '0;
                drt[s] <= '0;
                for (int w = 0; w < WAYS; w++) tg[s][w] <= '0;
            end
        end else begin
            if (poke) begin
                vld[pk_s][pk_w] <= 1'b1;
                drt[pk_s][pk_w] <= pk_d;
                tg[pk_s][pk_w] <= pk_t;
            end
            for (int w = 0; w < WAYS; w++) begin
                if (load_td[w]) tg[array_index][w] <= cur_tag;
                if (load_valid[w]) vld[array_index][w] <= valid_in;
                if (load_dirty[w]) drt[array_index][w] <= dirty_in;
            end
        end
    end

    always_comb begin
        for (int w = 0; w < WAYS; w++)
            m_hit[w] = vld[array_index][w] && (tg[array_index][w] == cur_tag);
    end

    assign way_hit   = ovr ? t_hit : m_hit;
    assign way_valid = ovr ? t_val : vld[array_index];
    assign way_dirty = ovr ? t_dty : drt[array_index];

    // Physical memory answers on the LAT-th cycle of each held strobe.
    int pc = 0;
    always @(negedge clk) begin
        if (!(pmem_read || pmem_write)) begin
            pc = 0;
            pmem_resp = 1'b0;
        end else begin
            pc = pmem_resp ? 1 : pc + 1;
            pmem_resp = (pc == LAT);
        end
    end

    int nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rd, wr;
        logic [3:0] idx, hit, val, dty;
        logic       resp;
        logic [1:0] sel;
        logic [3:0] ltd, ldy;
        logic       din;
    } vec_t;
    vec_t tbl [6];

    int a_cyc, a_rd, a_wr, a_wbway, a_hw, a_fd;
    logic a_wbsel;

    task automatic access(input logic w, input logic [3:0] idx, input logic [7:0] t);
        a_cyc = 0; a_rd = 0; a_wr = 0; a_wbway = -1; a_wbsel = 1'b1; a_hw = -1; a_fd = 0;
        mem_read = !w; mem_write = w; mem_index = idx; cur_tag = t;
        for (int i = 0; i < 100 && a_hw < 0; i++) begin
            #1;
            a_cyc++;
            if (pmem_read) a_rd++;
            if (pmem_write) begin
                a_wr++;
                a_wbway = int'(sel_way);
                if (!pmem_addr_sel) a_wbsel = 1'b0;
            end
            if (flush_done) a_fd++;
            if (mem_resp) a_hw = int'(sel_way);
            @(posedge clk); #1;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (a_hw < 0) chk("access timeout", 1, 0);
    endtask

    task automatic do_reset();
        mem_read = 1'b0; mem_write = 1'b0; flush_req = 1'b0;
        rst = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; clr = 1'b0;
    endtask

    task automatic poke_line(input logic [3:0] s, input logic [1:0] w, input logic d, input logic [7:0] t);
        pk_s = s; pk_w = w; pk_d = d; pk_t = t; poke = 1'b1;
        @(posedge clk); #1;
        poke = 1'b0;
    endtask

    int hit_seq [5] = '{0, 1, 2, 3, 0};
    logic [7:0] tag_seq [5] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA0};
    int nb, n, pw_rise, bad_sel;
    logic pw_prev, seen;
    logic [5:0] bursts [4];
    logic [11:0] loads;
    logic [3:0] dirt;

    initial begin
        mem_read = 0; mem_write = 0; flush_req = 0; mem_index = 4'd9; cur_tag = 0;
        ovr = 0; t_hit = 0; t_val = 0; t_dty = 0; clr = 1; poke = 0;
        pk_s = 0; pk_w = 0; pk_d = 0; pk_t = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset array_index", array_index, 9);
        chk("reset mem_resp", mem_resp, 0);
        chk("reset pmem strobes", {pmem_read, pmem_write}, 0);
        chk("reset loads", {load_td, load_valid, load_dirty}, 0);
        chk("reset misc", {flush_done, valid_in, dirty_in, datain_sel, pmem_addr_sel, sel_way}, 0);
        rst = 1'b0; clr = 1'b0;

        tbl[0] = '{1'b0, 1'b0, 4'd7,  4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 4'd3,  4'b0100, 4'b1111, 4'b0000, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 4'd5,  4'b0010, 4'b0011, 4'b0000, 1'b1, 2'd1, 4'b0010, 4'b0010, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 4'd9,  4'b1000, 4'b1111, 4'b0001, 1'b1, 2'd3, 4'b1000, 4'b1000, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 4'd15, 4'b0001, 4'b1111, 4'b1111, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 4'd2,  4'b0100, 4'b1111, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0};
        ovr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_read = tbl[i].rd; mem_write = tbl[i].wr; mem_index = tbl[i].idx;
            t_hit = tbl[i].hit; t_val = tbl[i].val; t_dty = tbl[i].dty;
            #1;
            chk($sformatf("vec%0d mem_resp", i), mem_resp, tbl[i].resp);
            chk($sformatf("vec%0d sel_way", i), sel_way, tbl[i].sel);
            chk($sformatf("vec%0d load_td", i), load_td, tbl[i].ltd);
            chk($sformatf("vec%0d load_dirty", i), load_dirty, tbl[i].ldy);
            chk($sformatf("vec%0d dirty_in", i), dirty_in, tbl[i].din);
            chk($sformatf("vec%0d idle outs", i), {load_valid, datain_sel, pmem_read, pmem_write}, 0);
            chk($sformatf("vec%0d array_index", i), array_index, tbl[i].idx);
            @(posedge clk); #1;
        end
        ovr = 1'b0;
        do_reset();

        access(1'b0, 4'd3, 8'hA0);
        chk("clean miss latency", a_cyc, 7);
        chk("clean miss pmem_read cycles", a_rd, LAT);
        chk("clean miss no pmem_write", a_wr, 0);
        chk("clean miss fill way", a_hw, 0);
        chk("fill valid", vld[3][0], 1);
        chk("fill clean", drt[3][0], 0);
        access(1'b0, 4'd3, 8'hB0); chk("invalid-first way1", a_hw, 1);
        access(1'b0, 4'd3, 8'hC0); chk("invalid-first way2", a_hw, 2);
        access(1'b0, 4'd3, 8'hD0); chk("invalid-first way3", a_hw, 3);
        for (int i = 0; i < 5; i++) begin
            access(1'b0, 4'd3, tag_seq[i]);
            chk($sformatf("hit%0d way", i), a_hw, hit_seq[i]);
            chk($sformatf("hit%0d latency", i), a_cyc, 1);
        end
        access(1'b0, 4'd3, 8'hE0);
        chk("plru victim way", a_hw, 2);
        chk("plru miss latency", a_cyc, 7);

        do_reset();
        access(1'b0, 4'd5, 8'hA0);
        access(1'b0, 4'd5, 8'hB0);
        access(1'b1, 4'd5, 8'hB0);
        chk("write hit way", a_hw, 1);
        chk("write hit latency", a_cyc, 1);
        chk("write hit sets dirty", drt[5][1], 1);
        access(1'b0, 4'd5, 8'hC0);
        access(1'b0, 4'd5, 8'hD0);
        access(1'b0, 4'd5, 8'hA0);
        access(1'b0, 4'd5, 8'hD0);
        access(1'b0, 4'd5, 8'hE0);
        chk("dirty miss latency", a_cyc, 12);
        chk("wb pmem_write cycles", a_wr, LAT);
        chk("wb pmem_read cycles", a_rd, LAT);
        chk("wb sel_way", a_wbway, 1);
        chk("wb pmem_addr_sel", a_wbsel, 1);
        chk("evicted way refilled", a_hw, 1);
        chk("dirty cleared after fill", drt[5][1], 0);

        do_reset();
        poke_line(4'd0, 2'd2, 1'b1, 8'd11);
        poke_line(4'd15, 2'd2, 1'b1, 8'd12);
        poke_line(4'd15, 2'd3, 1'b1, 8'd13);
        poke_line(4'd15, 2'd0, 1'b0, 8'd14);
        poke_line(4'd7, 2'd1, 1'b0, 8'd15);
        flush_req = 1'b1;
        nb = 0; bad_sel = 0; pw_prev = 1'b0; seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            #1;
            if (pmem_write && !pw_prev) begin
                if (nb < 4) bursts[nb] = {array_index, sel_way};
                nb++;
            end
            if (pmem_write && !pmem_addr_sel) bad_sel++;
            pw_prev = pmem_write;
            seen = flush_done;
            @(posedge clk); #1;
        end
        flush_req = 1'b0;
        chk("flush done seen", seen, 1);
        chk("flush burst count", nb, 3);
        chk("flush burst0 set/way", bursts[0], {4'd0, 2'd2});
        chk("flush burst1 set/way", bursts[1], {4'd15, 2'd2});
        chk("flush burst2 set/way", bursts[2], {4'd15, 2'd3});
        chk("flush pmem_addr_sel", bad_sel, 0);
        #1;
        chk("flush_done one cycle", flush_done, 0);
        dirt = '0;
        for (int s = 0; s < SETS; s++) dirt = dirt | drt[s];
        chk("all clean after flush", dirt, 0);

        do_reset();
        flush_req = 1'b1;
        access(1'b0, 4'd4, 8'hA0);
        chk("request beats flush latency", a_cyc, 7);
        chk("no flush_done during request", a_fd, 0);
        n = 0; pw_rise = 0; seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #2;
            n++;
            if (pmem_write) pw_rise++;
            seen = flush_done;
        end
        flush_req = 1'b0;
        chk("clean flush cycles", n, SETS);
        chk("clean flush no write-back", pw_rise, 0);

        do_reset();
        for (int w = 0; w < WAYS; w++) poke_line(4'd6, 2'(w), 1'b1, 8'(w + 1));
        mem_read = 1'b1; mem_index = 4'd6; cur_tag = 8'd9;
        #1;
        chk("miss cycle no strobe", pmem_write, 0);
        @(posedge clk); #2;
        chk("wb strobe", pmem_write, 1);
        chk("wb victim plru way0", sel_way, 0);
        #1 rst = 1'b1;
        #1;
        chk("async reset drops pmem_write", pmem_write, 0);
        chk("async reset no pmem_read", pmem_read, 0);
        loads = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            loads = loads | {load_td, load_valid, load_dirty};
        end
        chk("no load during reset", loads, 0);
        mem_read = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("victim still dirty", drt[6][0], 1);
        chk("victim still valid", vld[6][0], 1);
        access(1'b0, 4'd6, 8'd1);
        chk("post-reset hit latency", a_cyc, 1);
        chk("post-reset hit way", a_hw, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
